mf_cegen: RTL and testbench

Parametrised multi-channel clock-enable generator, the soft successor to the fixed five-output PLL wrapper. A single reference clock drives NUM_CH independent phase accumulators. Each accumulator emits a one-cycle enable pulse at a programmable fractional rate and phase offset. Increments and phases are runtime-reconfigurable through a shadow/commit interface, and a lock indicator mirrors PLL `locked` semantics so downstream logic can gate on it.

---
 rtl/mf_cegen.sv | 211 +++++++++++++++++++++
 tb/tb_mf_cegen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_cegen.sv
// mf_cegen: multi-channel fractional clock-enable generator.
//
// NUM_CH phase accumulators share one reference clock. Each one emits a
// single-cycle enable pulse whenever its accumulator wraps. Increments and
// start phases are staged in shadow registers and copied into the running
// set by a commit. A commit also restarts a settle window, and `locked`
// follows the same semantics as a PLL lock flag.
//
// Optional build macro: MF_CEGEN_DIVCLK_EN
//   When defined, adds div_out[NUM_CH-1:0]. Each bit toggles on every
//   cycle where the matching ce bit is high.
//
// FSM states:
//   state  | meaning
//   UNCONF | after reset; no active configuration, accumulators hold, ce=0
//   SETTLE | committed config running, ce masked, settle counter counting up
//   LOCKED | configuration stable, ce follows accumulator carries

module mf_cegen #(
  parameter int NUM_CH      = 5,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 256,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W      = $clog2(LOCK_CYCLES)
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
`ifdef MF_CEGEN_DIVCLK_EN
  ,
  output logic [NUM_CH-1:0] div_out
`endif
);

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run;

  logic [ACC_W-1:0]  sh_inc_q   [NUM_CH];
  logic [ACC_W-1:0]  sh_phase_q [NUM_CH];
  logic [ACC_W-1:0]  inc_q      [NUM_CH];
  logic [ACC_W-1:0]  acc_q      [NUM_CH];
  logic [ACC_W:0]    sum        [NUM_CH];
  logic [ACC_W-1:0]  commit_inc   [NUM_CH];
  logic [ACC_W-1:0]  commit_phase [NUM_CH];

  logic [NUM_CH-1:0] carry_q;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [NUM_CH-1:0] wr_sel;
  logic              wr_ok;

  // A write to a channel number that does not exist is dropped.
  assign wr_ok = cfg_we && (int'(cfg_ch) < NUM_CH);

  // Decode which channel shadow the current write targets.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_ok && (cfg_ch == CH_W'(i));
    end
  end

  // Commit data: a write in the same cycle bypasses the shadow so the
  // commit picks up the value being written.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      commit_inc[i]   = wr_sel[i] ? cfg_inc   : sh_inc_q[i];
      commit_phase[i] = wr_sel[i] ? cfg_phase : sh_phase_q[i];
    end
  end

  // Full-width add per channel; the extra MSB is the wrap carry.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // Next-state, settle counter and accumulator run enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run     = 1'b0;
    case (state_q)
      ST_UNCONF: begin
        state_d = ST_UNCONF;
      end
      ST_SETTLE: begin
        run   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d = ST_LOCKED;
          cnt_d   = cnt_q;
        end
      end
      ST_LOCKED: begin
        run = 1'b1;
      end
      default: begin
        state_d = ST_UNCONF;
      end
    endcase
    if (cfg_commit) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
    end
  end

  // State and settle counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNCONF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow registers; they never touch the running set until a commit.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_inc_q[i]   <= '0;
        sh_phase_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          sh_inc_q[i]   <= cfg_inc;
          sh_phase_q[i] <= cfg_phase;
        end
      end
    end
  end

  // Active increments and accumulators. A commit reloads the start phase
  // and drops any pending carry, so the restarted sequence is clean.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc_q[i] <= '0;
        acc_q[i] <= '0;
      end
      carry_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_commit) begin
          inc_q[i]   <= commit_inc[i];
          acc_q[i]   <= commit_phase[i];
          carry_q[i] <= 1'b0;
        end else if (run) begin
          {carry_q[i], acc_q[i]} <= sum[i];
        end
      end
    end
  end

  // The carry is published only while locked. The pulse that would be
  // registered on a commit edge is suppressed.
  always_comb begin
    ce_d = '0;
    if ((state_q == ST_LOCKED) && !cfg_commit) begin
      ce_d = carry_q;
    end
  end

  // Registered enable outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q <= '0;
    end else begin
      ce_q <= ce_d;
    end
  end

`ifdef MF_CEGEN_DIVCLK_EN
  logic [NUM_CH-1:0] div_q;

  // Half-rate toggles driven by the enables; they restart low on a commit.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (cfg_commit) begin
      div_q <= '0;
    end else begin
      div_q <= div_q ^ ce_q;
    end
  end

  assign div_out = div_q;
`endif

  assign ce       = ce_q;
  assign locked   = (state_q == ST_LOCKED);
  assign cfg_busy = (state_q == ST_SETTLE);

endmodule

// File: tb/tb_mf_cegen.sv
// Scoreboard bench for mf_cegen (NUM_CH=5, ACC_W=8, LOCK_CYCLES=16).
// The reference model computes outputs in closed form from the number of
// edges since the last commit. Expected values are queued per edge, and a
// negedge monitor pops each entry and compares it with the outputs.

module tb_mf_cegen;
  localparam int NCH  = 5;
  localparam int AW   = 8;
  localparam int LCK  = 16;
  localparam int MODV = 256;

  logic           refclk = 1'b0;
  logic           rst_n;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [AW-1:0]  cfg_inc;
  logic [AW-1:0]  cfg_phase;
  logic           cfg_commit;
  logic           cfg_busy;
  logic [NCH-1:0] ce;
  logic           locked;
`ifdef MF_CEGEN_DIVCLK_EN
  logic [NCH-1:0] div_out;
`endif

  mf_cegen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LCK)) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_commit(cfg_commit),
    .cfg_busy  (cfg_busy),
    .ce        (ce),
    .locked    (locked)
`ifdef MF_CEGEN_DIVCLK_EN
    ,
    .div_out   (div_out)
`endif
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [NCH-1:0] ce;
    logic           lk;
    logic           bz;
    logic [NCH-1:0] dv;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  int             sh_inc[NCH];
  int             sh_ph[NCH];
  int             act_inc[NCH];
  int             act_ph[NCH];
  bit             conf;
  int             m;
  logic [NCH-1:0] prev_ce;
  logic [NCH-1:0] dv_m;

  task automatic chk(input string nm, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, got, expv);
    end
  endtask

  // Add number k (k>=1 after a commit) wraps iff the integer quotient by
  // the modulus steps between k-1 and k.
  function automatic bit wraps(input int ph, input int inc, input int k);
    return ((ph + k * inc) / MODV) != ((ph + (k - 1) * inc) / MODV);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      sh_inc[i] = 0; sh_ph[i] = 0; act_inc[i] = 0; act_ph[i] = 0;
    end
    conf = 1'b0; m = 0; prev_ce = '0; dv_m = '0;
  endtask

  task automatic model_edge(input bit we, input int ch, input int inc, input int ph, input bit cm);
    exp_t e;
    if (we && ch < NCH) begin
      sh_inc[ch] = inc; sh_ph[ch] = ph;
    end
    if (cm) begin
      act_inc = sh_inc; act_ph = sh_ph; m = 0; conf = 1'b1; dv_m = '0;
    end else begin
      if (conf) m++;
      dv_m = dv_m ^ prev_ce;
    end
    e.ce = '0;
    for (int i = 0; i < NCH; i++)
      e.ce[i] = conf && (m >= LCK + 1) && wraps(act_ph[i], act_inc[i], m - 1);
    e.lk = conf && (m >= LCK);
    e.bz = conf && (m < LCK);
    e.dv = dv_m;
    prev_ce = e.ce;
    q.push_back(e);
  endtask

  task automatic cyc(input bit we, input int ch, input int inc, input int ph, input bit cm);
    cfg_we = we; cfg_ch = ch[2:0]; cfg_inc = inc[AW-1:0];
    cfg_phase = ph[AW-1:0]; cfg_commit = cm;
    @(posedge refclk);
    model_edge(we, ch, inc, ph, cm);
    #1;
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ce"}, int'(ce), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_busy"}, int'(cfg_busy), 0);
`ifdef MF_CEGEN_DIVCLK_EN
    chk({tag, "_div"}, int'(div_out), 0);
`endif
  endtask

  // Reset asserted between edges; the outputs must clear before any edge.
  task automatic async_reset(input string tag);
    @(negedge refclk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (3) @(posedge refclk);
    #3;
    rst_n = 1'b1;
    @(posedge refclk);
    #1;
  endtask

  // monitor: one expected entry per clocked edge
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ce", int'(ce), int'(e.ce));
        chk("locked", int'(locked), int'(e.lk));
        chk("cfg_busy", int'(cfg_busy), int'(e.bz));
`ifdef MF_CEGEN_DIVCLK_EN
        chk("div_out", int'(div_out), int'(e.dv));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, last, gap, r, inc, ch, ph;
    bit we, cm;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0;
    cfg_phase = '0; cfg_commit = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    #10;
    rst_n = 1'b1;
    @(posedge refclk); #1;

    idle(5);                                   // unconfigured: silent

    // lock sequence: ch0 inc=128
    cyc(1'b1, 0, 128, 0, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b1);
    idle(40);

    // phase offset: ch1 leads ch0 by two cycles, checked for >1000 cycles
    cyc(1'b1, 0, 64, 0, 1'b0);
    cyc(1'b1, 1, 64, 128, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b1);
    idle(1100);

    // fractional rate on ch2
    cyc(1'b1, 2, 3, 0, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b1);
    idle(LCK + 1);
    cnt = 0; last = -1;
    for (int i = 0; i < 2560; i++) begin
      cyc(1'b0, 0, 0, 0, 1'b0);
      if (ce[2]) begin
        if (last >= 0) begin
          gap = i - last;
          chk("frac_gap_85_86", int'(gap == 85 || gap == 86), 1);
        end
        last = i;
        cnt++;
      end
    end
    chk("frac_count", cnt, 30);

    // commit while locked, then a write to a nonexistent channel
    cyc(1'b0, 0, 0, 0, 1'b1);
    idle(25);
    cyc(1'b1, 7, 200, 77, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b1);
    idle(30);

    // write and commit on the same edge
    cyc(1'b1, 0, 192, 16, 1'b1);
    idle(40);

    // reset mid-SETTLE, then mid-LOCKED
    cyc(1'b1, 0, 128, 0, 1'b1);
    idle(5);
    async_reset("rst_settle");
    idle(30);
    cyc(1'b1, 3, 255, 1, 1'b0);
    cyc(1'b1, 0, 128, 0, 1'b1);
    idle(30);
    async_reset("rst_locked");
    idle(30);

    // randomized writes and commits, including out-of-range channels
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(99);
      we = (r < 20);
      ch = $urandom_range(7);
      case ($urandom_range(3))
        0: inc = $urandom_range(255);
        1: inc = $urandom_range(15);
        2: inc = 128 + $urandom_range(127);
        default: inc = ($urandom_range(1) == 0) ? 0 : 255;
      endcase
      ph = $urandom_range(255);
      cm = ($urandom_range(99) < 2);
      cyc(we, ch, inc, ph, cm);
    end

`ifdef MF_CEGEN_DIVCLK_EN
    // div_out[0] with inc=128: period 4, high two of every four cycles
    cyc(1'b1, 0, 128, 0, 1'b1);
    idle(LCK + 2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 0, 0, 0, 1'b0);
      cnt += int'(div_out[0]);
    end
    chk("div_duty", cnt, 20);
`endif

    @(negedge refclk);
    #1;
    chk("sb_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
